// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAMHelper port arbiter.
// Holds the default RAM window, word-index shift, strobe/mask widths and
// the byte-strobe to bit-mask expansion helper.
`ifndef DATA_BUS
`define DATA_BUS 63:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 63:0
`endif

package ram_port_arbiter_pkg;

  localparam logic [63:0] RAM_BASE_DEFAULT  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] RAM_BYTES_DEFAULT = 64'h0000_0000_0800_0000;
  localparam int          RAM_IDX_SHIFT     = 3;
  localparam int          STRB_W            = 8;
  localparam int          MASK_W            = STRB_W * 8;

  // Each strobe bit covers one byte lane of the 64-bit word.
  function automatic logic [MASK_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int k = 0; k < STRB_W; k++) begin
      m[k*8 +: 8] = {8{strb[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Combinational N-way round-robin pick.
// Ports:
//   req_i   - request vector, one bit per channel
//   ptr_i   - highest-priority channel this cycle
//   grant_o - one-hot grant (zero when no request)
//   idx_o   - encoded index of the granted channel (0 when no grant)
module ram_port_arbiter_rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o
);

  logic found;

  // Walk offsets 0..N-1 from the pointer; the first requesting channel wins.
  always_comb begin
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int off = 0; off < N; off++) begin
      for (int c = 0; c < N; c++) begin
        if (!found && req_i[c] && (c == ((int'(ptr_i) + off) % N))) begin
          found      = 1'b1;
          grant_o[c] = 1'b1;
          idx_o      = PTR_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// N-channel arbiter and bridge onto the single RAMHelper port.
// Two-stage pipeline: accept (round-robin) -> RAM issue -> registered response.
// Ports:
//   clk, rst                    - clock, async active-high reset
//   ch_req_valid/ready/we       - per-channel request handshake and direction
//   ch_req_addr/wdata/wstrb     - per-channel packed request payload
//   ch_resp_valid               - one-cycle response pulse to the owning channel
//   resp_rdata, resp_err        - shared response data and out-of-window flag
//   ram_ren/ridx/rdata          - RAMHelper read port
//   ram_wen/widx/wdata/wmask    - RAMHelper write port
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int          N_CH      = 2,
  parameter int          ADDR_W    = 64,
  parameter int          DATA_W    = 64,
  parameter logic [63:0] RAM_BASE  = RAM_BASE_DEFAULT,
  parameter logic [63:0] RAM_BYTES = RAM_BYTES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_req_valid,
  output logic [N_CH-1:0]          ch_req_ready,
  input  logic [N_CH-1:0]          ch_req_we,
  input  logic [N_CH*ADDR_W-1:0]   ch_req_addr,
  input  logic [N_CH*DATA_W-1:0]   ch_req_wdata,
  input  logic [N_CH*STRB_W-1:0]   ch_req_wstrb,
  output logic [N_CH-1:0]          ch_resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     resp_err,
  output logic                     ram_ren,
  output logic [63:0]              ram_ridx,
  input  logic [63:0]              ram_rdata,
  output logic                     ram_wen,
  output logic [63:0]              ram_widx,
  output logic [63:0]              ram_wdata,
  output logic [63:0]              ram_wmask
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [ADDR_W-1:0] WIN_LO = ADDR_W'(RAM_BASE);
  localparam logic [ADDR_W-1:0] WIN_HI = ADDR_W'(RAM_BASE + RAM_BYTES);

  logic [N_CH-1:0]   req_v;
  logic [N_CH-1:0]   grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              fire;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_off;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  logic              s1_valid_q, s1_valid_d;
  logic [PTR_W-1:0]  s1_id_q, s1_id_d;
  logic              s1_we_q, s1_we_d;
  logic              s1_err_q, s1_err_d;
  logic [63:0]       s1_idx_q, s1_idx_d;
  logic [DATA_W-1:0] s1_wdata_q, s1_wdata_d;
  logic [STRB_W-1:0] s1_wstrb_q, s1_wstrb_d;

  logic              rd_go, wr_go;

  logic [N_CH-1:0]   resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  // No grants while reset is held, so ready reads 0 during reset.
  assign req_v = ch_req_valid & {N_CH{~rst}};

  ram_port_arbiter_rr_arbiter #(
    .N     (N_CH),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i   (req_v),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  assign ch_req_ready = grant;
  assign fire         = |grant;

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (grant[c]) begin
        sel_addr  = ch_req_addr[c*ADDR_W +: ADDR_W];
        sel_we    = ch_req_we[c];
        sel_wdata = ch_req_wdata[c*DATA_W +: DATA_W];
        sel_wstrb = ch_req_wstrb[c*STRB_W +: STRB_W];
      end
    end
  end

  assign sel_off = sel_addr - WIN_LO;

  always_comb begin
    s1_valid_d = fire;
    s1_id_d    = grant_idx;
    s1_we_d    = sel_we;
    s1_err_d   = (sel_addr < WIN_LO) || (sel_addr >= WIN_HI);
    s1_idx_d   = 64'(sel_off >> RAM_IDX_SHIFT);
    s1_wdata_d = sel_wdata;
    s1_wstrb_d = sel_wstrb;
    rr_ptr_d   = rr_ptr_q;
    if (fire) begin
      rr_ptr_d = (grant_idx == PTR_W'(N_CH - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  assign rd_go = s1_valid_q & ~s1_we_q & ~s1_err_q;
  assign wr_go = s1_valid_q &  s1_we_q & ~s1_err_q;

  // Index/data/mask are zeroed when the matching enable is low.
  assign ram_ren   = rd_go;
  assign ram_ridx  = rd_go ? s1_idx_q : '0;
  assign ram_wen   = wr_go;
  assign ram_widx  = wr_go ? s1_idx_q : '0;
  assign ram_wdata = wr_go ? 64'(s1_wdata_q) : '0;
  assign ram_wmask = wr_go ? strb_to_mask(s1_wstrb_q) : '0;

  always_comb begin
    resp_valid_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (s1_valid_q && (s1_id_q == PTR_W'(c))) begin
        resp_valid_d[c] = 1'b1;
      end
    end
    resp_rdata_d = rd_go ? DATA_W'(ram_rdata) : '0;
    resp_err_d   = s1_valid_q & s1_err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_we_q      <= 1'b0;
      s1_err_q     <= 1'b0;
      s1_idx_q     <= '0;
      s1_wdata_q   <= '0;
      s1_wstrb_q   <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_we_q      <= s1_we_d;
      s1_err_q     <= s1_err_d;
      s1_idx_q     <= s1_idx_d;
      s1_wdata_q   <= s1_wdata_d;
      s1_wstrb_q   <= s1_wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign ch_resp_valid = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   ch_req_valid, ch_req_ready, ch_req_we, ch_resp_valid;
  logic [127:0] ch_req_addr, ch_req_wdata;
  logic [15:0]  ch_req_wstrb;
  logic [63:0]  resp_rdata;
  logic         resp_err;
  logic         ram_ren, ram_wen;
  logic [63:0]  ram_ridx, ram_rdata, ram_widx, ram_wdata, ram_wmask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.N_CH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_req_valid  (ch_req_valid),
    .ch_req_ready  (ch_req_ready),
    .ch_req_we     (ch_req_we),
    .ch_req_addr   (ch_req_addr),
    .ch_req_wdata  (ch_req_wdata),
    .ch_req_wstrb  (ch_req_wstrb),
    .ch_resp_valid (ch_resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .ram_ren       (ram_ren),
    .ram_ridx      (ram_ridx),
    .ram_rdata     (ram_rdata),
    .ram_wen       (ram_wen),
    .ram_widx      (ram_widx),
    .ram_wdata     (ram_wdata),
    .ram_wmask     (ram_wmask)
  );

  // RAM model: unwritten words return a fixed pattern derived from the index.
  function automatic logic [63:0] init_word(input logic [5:0] i);
    if (i == 6'd2) return 64'hDEAD_BEEF_0000_0002;
    return 64'hA5A5_0000_0000_0000 | {58'd0, i};
  endfunction

  logic [63:0] mem [0:63];
  bit   [63:0] wr_flag = '0;

  assign ram_rdata = wr_flag[ram_ridx[5:0]] ? mem[ram_ridx[5:0]] : init_word(ram_ridx[5:0]);

  always @(posedge clk) begin
    if (ram_wen) begin
      mem[ram_widx[5:0]] <= ((wr_flag[ram_widx[5:0]] ? mem[ram_widx[5:0]] : init_word(ram_widx[5:0]))
                             & ~ram_wmask) | (ram_wdata & ram_wmask);
      wr_flag[ram_widx[5:0]] <= 1'b1;
    end
  end

  task automatic set_ch(input int c, input logic v, input logic we, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [7:0] st);
    ch_req_valid[c]          = v;
    ch_req_we[c]             = we;
    ch_req_addr[c*64 +: 64]  = addr;
    ch_req_wdata[c*64 +: 64] = wd;
    ch_req_wstrb[c*8 +: 8]   = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ch(0, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 8'h00);
    set_ch(1, 1'b1, 1'b1, 64'h8000_0008, 64'd0, 8'hFF);
    tick(); tick();
    checks++; if (ch_req_ready !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", ch_req_ready); end
    checks++; if (ch_resp_valid !== 2'b00) begin failures++; $display("FAIL rst_resp_valid got=%b exp=00", ch_resp_valid); end
    checks++; if ({resp_rdata, resp_err} !== 65'd0) begin failures++; $display("FAIL rst_resp got=%h/%b exp=0/0", resp_rdata, resp_err); end
    checks++; if ({ram_ren, ram_wen} !== 2'b00) begin failures++; $display("FAIL rst_ram_en got=%b%b exp=00", ram_ren, ram_wen); end
    checks++; if ({ram_ridx, ram_widx, ram_wdata, ram_wmask} !== 256'd0) begin failures++; $display("FAIL rst_ram_bus got=%h %h %h %h exp=0", ram_ridx, ram_widx, ram_wdata, ram_wmask); end
    ch_req_valid = 2'b00;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    set_ch(0, 1'b1, 1'b0, 64'h8000_0010, 64'd0, 8'h00);
    #1;
    checks++; if (ch_req_ready !== 2'b01) begin failures++; $display("FAIL rd_ready got=%b exp=01", ch_req_ready); end
    tick();
    ch_req_valid = 2'b00;
    #1;
    checks++; if (ram_ren !== 1'b1 || ram_wen !== 1'b0) begin failures++; $display("FAIL rd_ren got=%b/%b exp=1/0", ram_ren, ram_wen); end
    checks++; if (ram_ridx !== 64'd2) begin failures++; $display("FAIL rd_ridx got=%h exp=2", ram_ridx); end
    tick();
    checks++; if (ch_resp_valid !== 2'b01) begin failures++; $display("FAIL rd_resp_valid got=%b exp=01", ch_resp_valid); end
    checks++; if (resp_rdata !== 64'hDEAD_BEEF_0000_0002) begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef00000002", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", resp_err); end
    tick();
    checks++; if (ch_resp_valid !== 2'b00) begin failures++; $display("FAIL rd_pulse got=%b exp=00", ch_resp_valid); end
  endtask

  task automatic test_write();
    set_ch(1, 1'b1, 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'b0000_1111);
    #1;
    checks++; if (ch_req_ready !== 2'b10) begin failures++; $display("FAIL wr_ready got=%b exp=10", ch_req_ready); end
    tick();
    ch_req_valid = 2'b00;
    #1;
    checks++; if (ram_wen !== 1'b1 || ram_ren !== 1'b0) begin failures++; $display("FAIL wr_wen got=%b/%b exp=1/0", ram_wen, ram_ren); end
    checks++; if (ram_widx !== 64'd1) begin failures++; $display("FAIL wr_widx got=%h exp=1", ram_widx); end
    checks++; if (ram_wdata !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL wr_wdata got=%h exp=1122334455667788", ram_wdata); end
    checks++; if (ram_wmask !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL wr_wmask got=%h exp=00000000ffffffff", ram_wmask); end
    tick();
    checks++; if (ch_resp_valid !== 2'b10) begin failures++; $display("FAIL wr_ack got=%b exp=10", ch_resp_valid); end
    checks++; if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin failures++; $display("FAIL wr_ack_data got=%h/%b exp=0/0", resp_rdata, resp_err); end
    // All-zero strobe write still enables the RAM and is acknowledged.
    set_ch(1, 1'b1, 1'b1, 64'h8000_0030, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    #1;
    tick();
    ch_req_valid = 2'b00;
    #1;
    checks++; if (ram_wen !== 1'b1 || ram_widx !== 64'd6 || ram_wmask !== 64'd0) begin failures++; $display("FAIL zstrb_wr got=%b/%h/%h exp=1/6/0", ram_wen, ram_widx, ram_wmask); end
    tick();
    checks++; if (ch_resp_valid !== 2'b10) begin failures++; $display("FAIL zstrb_ack got=%b exp=10", ch_resp_valid); end
    checks++; if (mem[6] !== 64'hA5A5_0000_0000_0006) begin failures++; $display("FAIL zstrb_mem got=%h exp=a5a5000000000006", mem[6]); end
  endtask

  task automatic test_round_robin();
    int cnt0, cnt1;
    logic [1:0]  exp_oh;
    logic [63:0] exp_idx, exp_data;
    cnt0 = 0;
    cnt1 = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_ch(0, 1'b1, 1'b0, 64'h8000_0018, 64'd0, 8'h00);
    set_ch(1, 1'b1, 1'b0, 64'h8000_0020, 64'd0, 8'h00);
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 6) ch_req_valid = 2'b00;
      #1;
      if (cyc < 6) begin
        exp_oh = (cyc % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (ch_req_ready !== exp_oh) begin failures++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", cyc, ch_req_ready, exp_oh); end
      end
      if (cyc >= 1 && cyc <= 6) begin
        exp_idx = ((cyc - 1) % 2 == 0) ? 64'd3 : 64'd4;
        checks++; if (ram_ren !== 1'b1 || ram_ridx !== exp_idx) begin failures++; $display("FAIL rr_ram cyc=%0d got=%b/%h exp=1/%h", cyc, ram_ren, ram_ridx, exp_idx); end
      end
      if (cyc >= 2) begin
        exp_oh   = ((cyc - 2) % 2 == 0) ? 2'b01 : 2'b10;
        exp_data = ((cyc - 2) % 2 == 0) ? 64'hA5A5_0000_0000_0003 : 64'hA5A5_0000_0000_0004;
        checks++; if (ch_resp_valid !== exp_oh || resp_rdata !== exp_data) begin failures++; $display("FAIL rr_resp cyc=%0d got=%b/%h exp=%b/%h", cyc, ch_resp_valid, resp_rdata, exp_oh, exp_data); end
        cnt0 += int'(ch_resp_valid[0]);
        cnt1 += int'(ch_resp_valid[1]);
      end
      tick();
    end
    checks++; if (cnt0 != 3 || cnt1 != 3) begin failures++; $display("FAIL rr_counts got=%0d/%0d exp=3/3", cnt0, cnt1); end
  endtask

  task automatic test_out_of_range();
    set_ch(0, 1'b1, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00);
    #1;
    checks++; if (ch_req_ready !== 2'b01) begin failures++; $display("FAIL oor_lo_ready got=%b exp=01", ch_req_ready); end
    tick();
    ch_req_valid = 2'b00;
    #1;
    checks++; if (ram_ren !== 1'b0 || ram_wen !== 1'b0) begin failures++; $display("FAIL oor_lo_en got=%b/%b exp=0/0", ram_ren, ram_wen); end
    tick();
    checks++; if (ch_resp_valid !== 2'b01 || resp_err !== 1'b1 || resp_rdata !== 64'd0) begin failures++; $display("FAIL oor_lo_resp got=%b/%b/%h exp=01/1/0", ch_resp_valid, resp_err, resp_rdata); end
    set_ch(0, 1'b1, 1'b1, 64'h8800_0000, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    #1;
    tick();
    ch_req_valid = 2'b00;
    #1;
    checks++; if (ram_ren !== 1'b0 || ram_wen !== 1'b0) begin failures++; $display("FAIL oor_hi_en got=%b/%b exp=0/0", ram_ren, ram_wen); end
    tick();
    checks++; if (ch_resp_valid !== 2'b01 || resp_err !== 1'b1 || resp_rdata !== 64'd0) begin failures++; $display("FAIL oor_hi_resp got=%b/%b/%h exp=01/1/0", ch_resp_valid, resp_err, resp_rdata); end
    // Last word inside the window is accepted.
    set_ch(0, 1'b1, 1'b0, 64'h87FF_FFF8, 64'd0, 8'h00);
    #1;
    tick();
    ch_req_valid = 2'b00;
    #1;
    checks++; if (ram_ren !== 1'b1 || ram_ridx !== 64'h0000_0000_00FF_FFFF) begin failures++; $display("FAIL last_word_ram got=%b/%h exp=1/ffffff", ram_ren, ram_ridx); end
    tick();
    checks++; if (ch_resp_valid !== 2'b01 || resp_err !== 1'b0) begin failures++; $display("FAIL last_word_resp got=%b/%b exp=01/0", ch_resp_valid, resp_err); end
  endtask

  task automatic test_back_to_back();
    set_ch(0, 1'b1, 1'b1, 64'h8000_0020, 64'hCAFE_F00D_1234_5678, 8'hFF);
    #1;
    tick();
    set_ch(0, 1'b1, 1'b0, 64'h8000_0020, 64'd0, 8'h00);
    #1;
    checks++; if (ch_req_ready !== 2'b01) begin failures++; $display("FAIL b2b_ready got=%b exp=01", ch_req_ready); end
    checks++; if (ram_wen !== 1'b1 || ram_widx !== 64'd4) begin failures++; $display("FAIL b2b_wen got=%b/%h exp=1/4", ram_wen, ram_widx); end
    tick();
    ch_req_valid = 2'b00;
    #1;
    checks++; if (ram_ren !== 1'b1 || ram_ridx !== 64'd4) begin failures++; $display("FAIL b2b_ren got=%b/%h exp=1/4", ram_ren, ram_ridx); end
    checks++; if (ch_resp_valid !== 2'b01 || resp_rdata !== 64'd0) begin failures++; $display("FAIL b2b_wack got=%b/%h exp=01/0", ch_resp_valid, resp_rdata); end
    tick();
    checks++; if (ch_resp_valid !== 2'b01 || resp_rdata !== 64'hCAFE_F00D_1234_5678) begin failures++; $display("FAIL b2b_raw got=%b/%h exp=01/cafef00d12345678", ch_resp_valid, resp_rdata); end
  endtask

  task automatic test_reset_mid();
    set_ch(0, 1'b1, 1'b1, 64'h8000_0028, 64'h9999_9999_9999_9999, 8'hFF);
    #1;
    tick();
    rst = 1'b1;
    ch_req_valid = 2'b00;
    #1;
    checks++; if (ram_wen !== 1'b0 || ram_widx !== 64'd0 || ram_wmask !== 64'd0) begin failures++; $display("FAIL mid_rst_wen got=%b/%h/%h exp=0/0/0", ram_wen, ram_widx, ram_wmask); end
    checks++; if ({ch_req_ready, ch_resp_valid, resp_err} !== 5'd0 || resp_rdata !== 64'd0) begin failures++; $display("FAIL mid_rst_outs got=%b/%b/%b/%h exp=0", ch_req_ready, ch_resp_valid, resp_err, resp_rdata); end
    tick();
    checks++; if (ch_resp_valid !== 2'b00) begin failures++; $display("FAIL mid_rst_resp got=%b exp=00", ch_resp_valid); end
    rst = 1'b0;
    tick();
    checks++; if (ch_resp_valid !== 2'b00) begin failures++; $display("FAIL mid_rst_late_resp got=%b exp=00", ch_resp_valid); end
    checks++; if ((wr_flag[5] ? mem[5] : init_word(6'd5)) !== 64'hA5A5_0000_0000_0005) begin failures++; $display("FAIL mid_rst_mem got=%h exp=a5a5000000000005", mem[5]); end
    // Pointer was 1 before reset; after release channel 0 must win.
    set_ch(0, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 8'h00);
    set_ch(1, 1'b1, 1'b0, 64'h8000_0008, 64'd0, 8'h00);
    #1;
    checks++; if (ch_req_ready !== 2'b01) begin failures++; $display("FAIL mid_rst_ptr got=%b exp=01", ch_req_ready); end
    tick();
    ch_req_valid = 2'b00;
    tick(); tick();
  endtask

  initial begin
    rst          = 1'b1;
    ch_req_valid = '0;
    ch_req_we    = '0;
    ch_req_addr  = '0;
    ch_req_wdata = '0;
    ch_req_wstrb = '0;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
